// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
// Data-side bus responder for the single-cycle core. Every access is decoded
// to word RAM, a small MMIO bank (tohost, console TX FIFO, 64-bit mtime) or
// unmapped space. Reads are purely combinational and have no side effects.
// Writes commit at the rising clock edge.
module dmem_mmio_responder #(
  parameter int unsigned     XLen      = 32,
  parameter int unsigned     NPos      = 1024,
  parameter logic [XLen-1:0] MmioBase  = 32'h0001_0000,
  parameter int unsigned     FifoDepth = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLen-1:0] dmem_addr_i,
  input  logic            dmem_we_i,
  input  logic [XLen-1:0] dmem_wdata_i,
  output logic [XLen-1:0] dmem_rdata_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic [7:0]      tx_data_o,
  output logic            done_o,
  output logic [XLen-1:0] exit_code_o,
  output logic            bad_access_o
);

  localparam int unsigned RamAw = $clog2(NPos);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [XLen-3:0] RamWords  = (XLen-2)'(NPos);
  localparam logic [CntW-1:0] FifoSlots = CntW'(FifoDepth);

  // Word offsets (byte offset >> 2) of the MMIO registers
  localparam logic [5:0] OffTohost  = 6'd0;
  localparam logic [5:0] OffConsole = 6'd1;
  localparam logic [5:0] OffMtimeLo = 6'd2;
  localparam logic [5:0] OffMtimeHi = 6'd3;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_TOHOST,
    TGT_CONSOLE,
    TGT_MTIME_LO,
    TGT_MTIME_HI,
    TGT_NONE
  } target_e;

  target_e          target;
  logic [XLen-3:0]  word_idx;
  logic [RamAw-1:0] ram_idx;
  logic             mmio_hit;
  logic [5:0]       mmio_word;
  logic             unused_addr_lsbs;

  logic wr_ram;
  logic wr_tohost;
  logic wr_console;
  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_unmapped;

  logic [XLen-1:0] ram [NPos];

  logic [7:0]      fifo_mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_pop;
  logic            overflow;
  logic [7:0]      last_data;
  logic [18:0]     console_status;

  logic [63:0] mtime;

  // Sub-word byte lanes alias onto their word, so the two LSBs never matter
  assign unused_addr_lsbs = ^dmem_addr_i[1:0];

  assign word_idx  = dmem_addr_i[XLen-1:2];
  assign ram_idx   = dmem_addr_i[RamAw+1:2];
  assign mmio_word = dmem_addr_i[7:2];

  // The MMIO bank is 256-byte aligned, so a match on the upper bits is enough
  assign mmio_hit = (dmem_addr_i[XLen-1:8] == MmioBase[XLen-1:8]);

  // Classify the current access into exactly one target
  always_comb begin
    target = TGT_NONE;
    if ((dmem_addr_i < MmioBase) && (word_idx < RamWords)) begin
      target = TGT_RAM;
    end else if (mmio_hit) begin
      case (mmio_word)
        OffTohost:  target = TGT_TOHOST;
        OffConsole: target = TGT_CONSOLE;
        OffMtimeLo: target = TGT_MTIME_LO;
        OffMtimeHi: target = TGT_MTIME_HI;
        default:    target = TGT_NONE;
      endcase
    end
  end

  assign wr_ram      = dmem_we_i && (target == TGT_RAM);
  assign wr_tohost   = dmem_we_i && (target == TGT_TOHOST);
  assign wr_console  = dmem_we_i && (target == TGT_CONSOLE);
  assign wr_mtime_lo = dmem_we_i && (target == TGT_MTIME_LO);
  assign wr_mtime_hi = dmem_we_i && (target == TGT_MTIME_HI);
  assign wr_unmapped = dmem_we_i && (target == TGT_NONE);

  // Word RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= dmem_wdata_i;
    end
  end

  // Console FIFO: fullness is judged before any same-edge pop, so a push
  // into a full FIFO is dropped even while a byte is leaving
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FifoSlots);
  assign fifo_push  = wr_console && !fifo_full;
  assign fifo_pop   = tx_valid_o && tx_ready_i;

  assign tx_valid_o = !fifo_empty;

  // While empty the output keeps showing the last byte that left
  assign tx_data_o = fifo_empty ? last_data : fifo_mem[rd_ptr];

  assign console_status = {overflow, fifo_full, fifo_empty, 16'(fifo_count)};

  // FIFO byte storage; stale entries are never visible past the count
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= dmem_wdata_i[7:0];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the last popped byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      last_data  <= 8'h00;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_data <= fifo_mem[rd_ptr];
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (wr_console && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Free-running 64-bit timer; a half-write replaces that half and skips the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= 64'd0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= dmem_wdata_i[31:0];
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= dmem_wdata_i[31:0];
    end else begin
      mtime <= mtime + 64'd1;
    end
  end

  // Completion flag: only the first tohost write is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o      <= 1'b0;
      exit_code_o <= '0;
    end else if (wr_tohost && !done_o) begin
      done_o      <= 1'b1;
      exit_code_o <= dmem_wdata_i;
    end
  end

  // One-cycle flag after any write that landed nowhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_access_o <= 1'b0;
    end else begin
      bad_access_o <= wr_unmapped;
    end
  end

  // Zero-latency read mux; unmapped space reads as zero
  always_comb begin
    dmem_rdata_o = '0;
    case (target)
      TGT_RAM:      dmem_rdata_o = ram[ram_idx];
      TGT_TOHOST:   dmem_rdata_o = exit_code_o;
      TGT_CONSOLE:  dmem_rdata_o = XLen'(console_status);
      TGT_MTIME_LO: dmem_rdata_o = XLen'(mtime[31:0]);
      TGT_MTIME_HI: dmem_rdata_o = XLen'(mtime[63:32]);
      default:      dmem_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder
// Directed scenarios followed by random traffic, all compared against a
// behavioural model built from a byte queue, a word array and a 64-bit count.
module tb_dmem_mmio_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          NPOS  = 1024;
  localparam int          DEPTH = 8;

  localparam int C_RAM     = 0;
  localparam int C_TOHOST  = 1;
  localparam int C_CONSOLE = 2;
  localparam int C_LO      = 3;
  localparam int C_HI      = 4;
  localparam int C_NONE    = 5;

  logic        clk;
  logic        rst_n;
  logic [31:0] dmem_addr_i;
  logic        dmem_we_i;
  logic [31:0] dmem_wdata_i;
  logic [31:0] dmem_rdata_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  tx_data_o;
  logic        done_o;
  logic [31:0] exit_code_o;
  logic        bad_access_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0] ram_m [NPOS];
  bit        ram_ok [NPOS];
  bit [7:0]  q_m [$];
  bit        ovf_m;
  bit [7:0]  last_m;
  bit        done_m;
  bit [31:0] exit_m;
  bit        bad_m;
  bit [63:0] mtime_m;

  dmem_mmio_responder #(
    .XLen(32), .NPos(NPOS), .MmioBase(BASE), .FifoDepth(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dmem_addr_i(dmem_addr_i),
    .dmem_we_i(dmem_we_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_rdata_o(dmem_rdata_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o),
    .done_o(done_o),
    .exit_code_o(exit_code_o),
    .bad_access_o(bad_access_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int classify(input bit [31:0] addr);
    bit [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    if (a < BASE && (a / 4) < NPOS) return C_RAM;
    if (a >= BASE && (a - BASE) < 256) begin
      case (a - BASE)
        0:       return C_TOHOST;
        4:       return C_CONSOLE;
        8:       return C_LO;
        12:      return C_HI;
        default: return C_NONE;
      endcase
    end
    return C_NONE;
  endfunction

  // Returns 0 when the expected value is unknown (never-written RAM)
  function automatic bit modelRead(input bit [31:0] addr, output bit [31:0] v);
    int c;
    int n;
    c = classify(addr);
    n = q_m.size();
    v = 32'h0;
    case (c)
      C_RAM: begin
        if (!ram_ok[addr / 4]) return 1'b0;
        v = ram_m[addr / 4];
      end
      C_TOHOST:  v = exit_m;
      C_CONSOLE: v = (32'(ovf_m) << 18) | (32'(n == DEPTH) << 17) |
                     (32'(n == 0) << 16) | 32'(n);
      C_LO:      v = mtime_m[31:0];
      C_HI:      v = mtime_m[63:32];
      default:   v = 32'h0;
    endcase
    return 1'b1;
  endfunction

  task automatic modelStep(input bit [31:0] addr, input bit we,
                           input bit [31:0] wdata, input bit ready);
    int c;
    bit was_full;
    bit do_pop;
    c        = classify(addr);
    was_full = (q_m.size() == DEPTH);
    do_pop   = (q_m.size() != 0) && ready;
    bad_m    = we && (c == C_NONE);
    if (we && c == C_LO)      mtime_m[31:0]  = wdata;
    else if (we && c == C_HI) mtime_m[63:32] = wdata;
    else                      mtime_m        = mtime_m + 64'd1;
    if (we && c == C_RAM) begin
      ram_m[addr / 4]  = wdata;
      ram_ok[addr / 4] = 1'b1;
    end
    if (we && c == C_TOHOST && !done_m) begin
      done_m = 1'b1;
      exit_m = wdata;
    end
    if (do_pop) last_m = q_m.pop_front();
    if (we && c == C_CONSOLE) begin
      if (was_full) ovf_m = 1'b1;
      else          q_m.push_back(wdata[7:0]);
    end
  endtask

  task automatic modelReset();
    q_m.delete();
    ovf_m   = 1'b0;
    last_m  = 8'h00;
    done_m  = 1'b0;
    exit_m  = 32'h0;
    bad_m   = 1'b0;
    mtime_m = 64'd0;
  endtask

  task automatic checkState(input bit [31:0] addr);
    bit [31:0] exp;
    if (modelRead(addr, exp)) checkOutput("rdata", dmem_rdata_o, exp);
    checkOutput("tx_valid", 32'(tx_valid_o), 32'(q_m.size() != 0));
    checkOutput("tx_data", 32'(tx_data_o),
                32'((q_m.size() != 0) ? q_m[0] : last_m));
    checkOutput("done", 32'(done_o), 32'(done_m));
    checkOutput("exit_code", exit_code_o, exit_m);
    checkOutput("bad_access", 32'(bad_access_o), 32'(bad_m));
  endtask

  // Entered and left at posedge+1: drive, check combinational view, clock
  task automatic applyStimulus(input bit [31:0] addr, input bit we,
                               input bit [31:0] wdata, input bit ready);
    dmem_addr_i  = addr;
    dmem_we_i    = we;
    dmem_wdata_i = wdata;
    tx_ready_i   = ready;
    #2;
    checkState(addr);
    @(posedge clk);
    modelStep(addr, we, wdata, ready);
    #1;
  endtask

  task automatic peekRead(input string tag, input bit [31:0] addr,
                          input bit [31:0] expected);
    dmem_we_i   = 1'b0;
    dmem_addr_i = addr;
    #1;
    checkOutput(tag, dmem_rdata_o, expected);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once
  task automatic resetDut();
    dmem_we_i  = 1'b0;
    tx_ready_i = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    checkOutput("rst_tx_data", 32'(tx_data_o), 32'h0);
    checkOutput("rst_done", 32'(done_o), 32'h0);
    checkOutput("rst_exit_code", exit_code_o, 32'h0);
    checkOutput("rst_bad_access", 32'(bad_access_o), 32'h0);
    modelReset();
    #1;
    rst_n = 1'b1;
  endtask

  function automatic bit [31:0] randomAddr();
    bit [31:0] unm [5];
    unm[0] = 32'h0000_1000;
    unm[1] = BASE + 32'h10;
    unm[2] = BASE + 32'h40;
    unm[3] = BASE + 32'hFC;
    unm[4] = 32'h8000_0000;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      4:          return BASE + 32'($urandom_range(0, 3));
      5, 6:       return BASE + 32'h4;
      7:          return BASE + (($urandom_range(0, 1) == 1) ? 32'hC : 32'h8);
      8:          return unm[$urandom_range(0, 4)];
      default:    return 32'h0000_0FFC + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    bit [31:0] a;
    rst_n        = 1'b0;
    dmem_addr_i  = 32'h0;
    dmem_we_i    = 1'b0;
    dmem_wdata_i = 32'h0;
    tx_ready_i   = 1'b0;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetDut();

    $display("[TB] RAM write/read and aliasing");
    applyStimulus(32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
    peekRead("ram_word", 32'h10, 32'hDEAD_BEEF);
    peekRead("ram_alias", 32'h13, 32'hDEAD_BEEF);
    applyStimulus(32'h1000, 1'b0, 32'h0, 1'b0);
    peekRead("beyond_ram", 32'h1000, 32'h0);

    $display("[TB] Console with backpressure");
    applyStimulus(BASE + 4, 1'b1, 32'h48, 1'b0);
    checkOutput("first_valid", 32'(tx_valid_o), 32'h1);
    checkOutput("first_data", 32'(tx_data_o), 32'h48);
    applyStimulus(BASE + 4, 1'b1, 32'h69, 1'b0);
    checkOutput("held_data", 32'(tx_data_o), 32'h48);
    peekRead("status_two", BASE + 4, 32'h0000_0002);
    applyStimulus(BASE + 4, 1'b0, 32'h0, 1'b1);
    checkOutput("second_data", 32'(tx_data_o), 32'h69);
    applyStimulus(BASE + 4, 1'b0, 32'h0, 1'b1);
    checkOutput("drained_valid", 32'(tx_valid_o), 32'h0);
    peekRead("status_empty", BASE + 4, 32'h0001_0000);

    $display("[TB] Console overflow");
    for (int i = 0; i < 9; i++) applyStimulus(BASE + 4, 1'b1, 32'(i), 1'b0);
    peekRead("status_ovf", BASE + 4, 32'h0006_0008);
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_byte", 32'(tx_data_o), 32'(i));
      applyStimulus(32'h0, 1'b0, 32'h0, 1'b1);
    end
    peekRead("status_after_drain", BASE + 4, 32'h0005_0000);

    $display("[TB] mtime carry and counting");
    applyStimulus(BASE + 8, 1'b1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(BASE + 12, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h0, 1'b0, 32'h0, 1'b0);
    peekRead("mtime_hi_carry", BASE + 12, 32'h1);
    peekRead("mtime_lo_carry", BASE + 8, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(32'h0, 1'b0, 32'h0, 1'b0);
    peekRead("mtime_lo_ten", BASE + 8, 32'd10);

    $display("[TB] tohost and unmapped write");
    applyStimulus(BASE, 1'b1, 32'h1, 1'b0);
    checkOutput("done_set", 32'(done_o), 32'h1);
    checkOutput("exit_first", exit_code_o, 32'h1);
    applyStimulus(BASE, 1'b1, 32'h5, 1'b0);
    checkOutput("exit_kept", exit_code_o, 32'h1);
    applyStimulus(BASE + 32'h40, 1'b1, 32'h123, 1'b0);
    checkOutput("bad_pulse", 32'(bad_access_o), 32'h1);
    applyStimulus(32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("bad_cleared", 32'(bad_access_o), 32'h0);

    $display("[TB] Reset mid-run");
    for (int i = 0; i < 3; i++) applyStimulus(BASE + 4, 1'b1, 32'hA0 + 32'(i), 1'b0);
    checkOutput("queued_valid", 32'(tx_valid_o), 32'h1);
    resetDut();
    peekRead("status_after_reset", BASE + 4, 32'h0001_0000);
    peekRead("mtime_after_reset", BASE + 8, 32'h0);
    applyStimulus(BASE + 8, 1'b0, 32'h0, 1'b0);
    applyStimulus(BASE + 8, 1'b0, 32'h0, 1'b0);
    peekRead("ram_survives_reset", 32'h10, 32'hDEAD_BEEF);

    $display("[TB] Random traffic");
    applyStimulus(32'h0, 1'b0, 32'h0, 1'b0);
    resetDut();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) resetDut();
      a = randomAddr();
      applyStimulus(a, ($urandom_range(0, 1) == 1), $urandom,
                    ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-memory-side responder for the single-cycle RISC-V core's dmem bus (address, write-enable, write data in; read data out).
- Decodes every bus access to one of three targets:
  - word RAM;
  - a small MMIO register bank: tohost, console TX FIFO, 64-bit mtime;
  - unmapped space.
- Replaces the bare data RAM in core-level benches, so programs can print characters and signal completion.

Parameters:
- XLen, 32, data/address width.
- NPos, 1024, RAM depth in words (power of 2).
- MmioBase, 32'h0001_0000, byte base address of the MMIO bank (XLen-wide, 256-byte aligned).
- FifoDepth, 8, console FIFO depth in entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- dmem_addr_i  in  XLen  byte address from core.
- dmem_we_i  in  1  write enable; a write commits at posedge.
- dmem_wdata_i  in  XLen  write data.
- dmem_rdata_o  out  XLen  read data, combinational from dmem_addr_i.
- tx_valid_o  out  1  console byte available (FIFO not empty).
- tx_ready_i  in  1  sink accepts byte.
- tx_data_o  out  8  FIFO head byte.
- done_o  out  1  sticky, set by first tohost write.
- exit_code_o  out  XLen  value of first tohost write.
- bad_access_o  out  1  one-cycle pulse after a write to unmapped space.

Behaviour:
- Reset is rst_n (asynchronous, active-low); clock is clk.
- Reset values, applied immediately on rst_n low:
  - tx_valid_o=0, tx_data_o=0;
  - done_o=0, exit_code_o=0, bad_access_o=0;
  - FIFO pointers and count=0, overflow=0, mtime=0.
  - RAM contents are not reset.
- Address handling: dmem_addr_i[1:0] is ignored (word access only; sub-word aliases to its word).
- Decode:
  - RAM when addr < MmioBase and addr[XLen-1:2] < NPos.
  - MMIO when MmioBase ≤ addr < MmioBase+0x100, by offset addr[7:0] & ~3.
  - Everything else is unmapped.
- Reads: combinational, zero-latency, with no side effects. Unmapped addresses and unused MMIO offsets read 0.
- RAM writes: commit at the posedge with dmem_we_i=1. A read of the same word in the next cycle returns the new value.
- MMIO map:
  - 0x00 TOHOST
    - W: if done_o=0, the next cycle has done_o=1 and exit_code_o=wdata. Later writes are ignored.
    - R: exit_code_o.
  - 0x04 CONSOLE
    - W: pushes wdata[7:0] if the FIFO is not full at that edge. If full, the byte is dropped and the sticky overflow bit is set.
    - A push while full is rejected even if a pop occurs at the same edge.
    - R (status): [15:0] count, [16] empty, [17] full, [18] overflow; other bits 0.
  - 0x08 MTIME_LO, R/W.
  - 0x0C MTIME_HI, R/W.
- mtime: 64-bit counter, +1 every clock after reset release.
  - A write to LO or HI replaces that half at the edge, and no increment is applied that cycle.
  - The carry from LO to HI is a normal 64-bit increment.
  - HI/LO reads are not snapshotted.
- FIFO:
  - Registered storage. A byte written at edge N has tx_valid_o=1 from edge N onward.
  - tx_data_o is the head byte. Valid/data are held stable until a tx_ready_i handshake.
  - A pop occurs at a posedge with tx_valid_o & tx_ready_i.
  - A simultaneous push (not full) and pop leaves count unchanged.
  - Pointers wrap modulo FifoDepth. count ranges 0..FifoDepth.
  - When empty, tx_valid_o=0 and tx_data_o holds its last value (0 after reset).
- Unmapped write: no state change, bad_access_o=1 for exactly the following cycle. Unused MMIO offsets are also unmapped.
- Reset mid-operation: FIFO contents are discarded, tx_valid_o drops asynchronously, and all sticky state clears.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000013 -> both return 0xDEADBEEF. Read 0x00001000 (beyond NPos, below MmioBase) -> 0.
- Console backpressure: tx_ready_i=0, write 0x48 then 0x69 to MmioBase+4:
  - tx_valid_o=1 and tx_data_o=0x48 after the first edge, held stable;
  - status read = 0x00000002;
  - then tx_ready_i=1 -> 0x48 then 0x69 handshake, tx_valid_o=0 and status=0x00010000.
- Overflow: tx_ready_i=0, 9 console writes of bytes 0..8:
  - status = 0x00060008 (count 8, full, overflow);
  - draining yields exactly 0..7 and status = 0x00050000.
- mtime:
  - write LO=0xFFFFFFFF and HI=0x00000000, then read one cycle after the HI write -> HI=1, LO=0;
  - 10 idle cycles later, LO=10.
- tohost:
  - write 0x00000001 -> done_o=1 and exit_code_o=1 next cycle;
  - a subsequent write of 0x5 leaves exit_code_o=1;
  - a write to MmioBase+0x40 -> bad_access_o pulses for one cycle.
- Reset mid-run: 3 bytes queued, done_o=1, mtime running; pulse rst_n low between edges -> tx_valid_o, done_o and exit_code_o go 0 immediately; status=0x00010000 and mtime restarts from 0.
